// File: rtl/avalon_be_splitter_pkg.sv
// Shared definitions for the byteenable splitter: supported lane patterns
// accepted by the downstream register, and the controller state encoding.
package avalon_be_splitter_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BE_ALL     = 4'b1111;
    localparam logic [BE_W-1:0] BE_LO_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_HI_HALF = 4'b1100;
    localparam logic [BE_W-1:0] BE_B0      = 4'b0001;
    localparam logic [BE_W-1:0] BE_B1      = 4'b0010;
    localparam logic [BE_W-1:0] BE_B2      = 4'b0100;
    localparam logic [BE_W-1:0] BE_B3      = 4'b1000;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

endpackage

// File: rtl/avalon_be_splitter_if.sv
// Avalon-MM slave bus seen by the splitter. The master modport is the
// requester side, the slave modport is the splitter itself.
interface avalon_be_splitter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              avs_write;
    logic              avs_read;
    logic [DATA_W-1:0] avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_write,
        output avs_read,
        output avs_writedata,
        output avs_byteenable,
        input  avs_waitrequest,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_write,
        input  avs_read,
        input  avs_writedata,
        input  avs_byteenable,
        output avs_waitrequest,
        output avs_readdata,
        output avs_readdatavalid
    );
endinterface

// File: rtl/avalon_be_splitter_be_chunk_pick.sv
// Picks the next register-supported lane pattern out of an arbitrary
// byteenable mask. Halves are preferred over single bytes so that any mask
// is covered in at most two chunks.
module be_chunk_pick
    import avalon_be_splitter_pkg::*;
(
    input  logic [BE_W-1:0] mask,
    output logic [BE_W-1:0] chunk
);

    // Priority pick: full word, low half, high half, then lowest single byte.
    always_comb begin
        chunk = BE_NONE;
        if (mask == BE_ALL) begin
            chunk = BE_ALL;
        end else if (mask[1:0] == 2'b11) begin
            chunk = BE_LO_HALF;
        end else if (mask[3:2] == 2'b11) begin
            chunk = BE_HI_HALF;
        end else if (mask[0]) begin
            chunk = BE_B0;
        end else if (mask[1]) begin
            chunk = BE_B1;
        end else if (mask[2]) begin
            chunk = BE_B2;
        end else if (mask[3]) begin
            chunk = BE_B3;
        end
    end

endmodule

// File: rtl/avalon_be_splitter.sv
// Avalon-MM front end for a byte-enabled register that only understands a
// subset of byteenable patterns. Unsupported masks are issued as two
// supported chunks, stalling the master for one cycle with waitrequest.
// Reads return the register value with a fixed one-cycle latency.
// Optional: define BE_SPLIT_STATS_EN to add a saturating split_count output.
module avalon_be_splitter
    import avalon_be_splitter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    avalon_be_splitter_if.slave   avs,
    output logic [DATA_W-1:0]     D,
    output logic [BE_W-1:0]       byteenable,
    input  logic [DATA_W-1:0]     Q
`ifdef BE_SPLIT_STATS_EN
    ,
    output logic [15:0]           split_count
`endif
);

    state_e          state;
    logic [BE_W-1:0] rem;
    logic [BE_W-1:0] pick_mask;
    logic [BE_W-1:0] chunk;
    logic [BE_W-1:0] rem_next;
    logic            write_acc;
    logic            read_acc;
    logic            split_acc;

    // One shared picker: the incoming mask in IDLE, the leftover in SPLIT.
    assign pick_mask = (state == SPLIT) ? rem : avs.avs_byteenable;

    be_chunk_pick u_pick (
        .mask  (pick_mask),
        .chunk (chunk)
    );

    // Write wins over a simultaneous read; the read is simply not accepted.
    assign write_acc = (state == IDLE) && avs.avs_write;
    assign read_acc  = (state == IDLE) && avs.avs_read && !avs.avs_write;
    assign rem_next  = avs.avs_byteenable & ~chunk;
    assign split_acc = write_acc && (rem_next != BE_NONE);

    assign avs.avs_waitrequest = (state == SPLIT);

    // Controller: issues chunks, captures read data and tracks the leftover mask.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            rem                   <= BE_NONE;
            D                     <= '0;
            byteenable            <= BE_NONE;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            byteenable            <= BE_NONE;
            avs.avs_readdatavalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (write_acc) begin
                        D          <= avs.avs_writedata;
                        byteenable <= chunk;
                        rem        <= rem_next;
                        if (rem_next != BE_NONE) begin
                            state <= SPLIT;
                        end
                    end else if (read_acc) begin
                        avs.avs_readdata      <= Q;
                        avs.avs_readdatavalid <= 1'b1;
                    end
                end
                SPLIT: begin
                    // D is held from the accepted write.
                    byteenable <= chunk;
                    rem        <= BE_NONE;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    rem   <= BE_NONE;
                end
            endcase
        end
    end

`ifdef BE_SPLIT_STATS_EN
    // Saturating count of accepted writes that needed two chunks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            split_count <= '0;
        end else if (split_acc && (split_count != 16'hFFFF)) begin
            split_count <= split_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_be_splitter.sv
// Self-checking bench for avalon_be_splitter: a directed table over all 16
// byteenable values, hand-written multi-cycle sequences, and a randomized
// run checked against a byte-level memory model.
module tb_avalon_be_splitter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] d_out;
    logic [3:0]  be_out;
    logic [31:0] q = '0;
`ifdef BE_SPLIT_STATS_EN
    logic [15:0] split_count;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int proto_viol = 0;

    avalon_be_splitter_if #(.DATA_W(32)) bus ();

    avalon_be_splitter #(.DATA_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .avs        (bus),
        .D          (d_out),
        .byteenable (be_out),
        .Q          (q)
`ifdef BE_SPLIT_STATS_EN
        ,
        .split_count(split_count)
`endif
    );

    always #5 clock = ~clock;

    // Downstream register: captures the enabled lanes of D on each edge.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (be_out[i]) q[8*i +: 8] <= d_out[8*i +: 8];
        end
    end

    // The master must never assert write and read together.
    always @(negedge clock) begin
        if (bus.avs_write && bus.avs_read) begin
            proto_viol <= proto_viol + 1;
            $display("FAIL protocol: write and read asserted together at %0t", $time);
        end
    end

    typedef struct {
        logic [3:0] be;
        logic [3:0] c1;
        logic [3:0] c2;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic bit supported(input logic [3:0] p);
        return p inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // Drives a write and returns 1 time unit after the accepting edge.
    task automatic write_accept(input logic [31:0] data, input logic [3:0] be);
        int n;
        bus.avs_writedata  = data;
        bus.avs_byteenable = be;
        bus.avs_write      = 1'b1;
        n = 0;
        @(negedge clock);
        while (bus.avs_waitrequest && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("write_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
        bus.avs_write = 1'b0;
    endtask

    // Drives a read and checks the returned data in the following cycle.
    task automatic do_read(input string name, input logic [31:0] exp);
        int n;
        bus.avs_read = 1'b1;
        n = 0;
        @(negedge clock);
        while (bus.avs_waitrequest && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("read_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
        bus.avs_read = 1'b0;
        @(negedge clock);
        check({name, "_rdv"}, {31'd0, bus.avs_readdatavalid}, 32'd1);
        check({name, "_data"}, bus.avs_readdata, exp);
        @(negedge clock);
        check({name, "_rdv_pulse"}, {31'd0, bus.avs_readdatavalid}, 32'd0);
    endtask

    task automatic clear_reg();
        write_accept(32'h0, 4'hF);
        @(negedge clock);
        @(negedge clock);
    endtask

    logic [31:0] mem_model;
    logic [31:0] data;
    logic [3:0]  be, c1, c2;
    logic        w1;
    int          exp_n, got_n, nz_seen;
`ifdef BE_SPLIT_STATS_EN
    logic [15:0] sc0;
`endif

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0000};
        vecs[2]  = '{4'b0010, 4'b0010, 4'b0000};
        vecs[3]  = '{4'b0011, 4'b0011, 4'b0000};
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0000};
        vecs[5]  = '{4'b0101, 4'b0001, 4'b0100};
        vecs[6]  = '{4'b0110, 4'b0010, 4'b0100};
        vecs[7]  = '{4'b0111, 4'b0011, 4'b0100};
        vecs[8]  = '{4'b1000, 4'b1000, 4'b0000};
        vecs[9]  = '{4'b1001, 4'b0001, 4'b1000};
        vecs[10] = '{4'b1010, 4'b0010, 4'b1000};
        vecs[11] = '{4'b1011, 4'b0011, 4'b1000};
        vecs[12] = '{4'b1100, 4'b1100, 4'b0000};
        vecs[13] = '{4'b1101, 4'b1100, 4'b0001};
        vecs[14] = '{4'b1110, 4'b1100, 4'b0010};
        vecs[15] = '{4'b1111, 4'b1111, 4'b0000};

        bus.avs_write      = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;

        // Reset state
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd0);
        check("rst_byteenable", {28'd0, be_out}, 32'd0);
        check("rst_D", d_out, 32'd0);
        check("rst_readdata", bus.avs_readdata, 32'd0);
        check("rst_rdv", {31'd0, bus.avs_readdatavalid}, 32'd0);
`ifdef BE_SPLIT_STATS_EN
        check("rst_split_count", {16'd0, split_count}, 32'd0);
`endif

        // Full-word write
        clear_reg();
        write_accept(32'hDEADBEEF, 4'hF);
        @(negedge clock);
        check("full_be", {28'd0, be_out}, 32'hF);
        check("full_wait", {31'd0, bus.avs_waitrequest}, 32'd0);
        @(negedge clock);
        check("full_be_off", {28'd0, be_out}, 32'd0);
        check("full_q", q, 32'hDEADBEEF);

        // Split 0111 over all-ones: upper byte must survive
        write_accept(32'hFFFFFFFF, 4'hF);
        @(negedge clock);
        @(negedge clock);
        write_accept(32'h11223344, 4'b0111);
        @(negedge clock);
        check("s0111_c1", {28'd0, be_out}, 32'b0011);
        check("s0111_wait1", {31'd0, bus.avs_waitrequest}, 32'd1);
        @(negedge clock);
        check("s0111_c2", {28'd0, be_out}, 32'b0100);
        check("s0111_wait2", {31'd0, bus.avs_waitrequest}, 32'd0);
        @(negedge clock);
        check("s0111_q", q, 32'hFF223344);

        // Sweep of all byteenable values over a cleared register
        for (int i = 0; i < 16; i++) begin
            clear_reg();
            write_accept(32'hA5A5A5A5, vecs[i].be);
            @(negedge clock);
            check($sformatf("sweep%0d_c1", i), {28'd0, be_out}, {28'd0, vecs[i].c1});
            check($sformatf("sweep%0d_D", i), d_out, 32'hA5A5A5A5);
            check($sformatf("sweep%0d_wait", i), {31'd0, bus.avs_waitrequest},
                  {31'd0, vecs[i].c2 != 4'b0000});
            @(negedge clock);
            check($sformatf("sweep%0d_c2", i), {28'd0, be_out}, {28'd0, vecs[i].c2});
            @(negedge clock);
            check($sformatf("sweep%0d_idle", i), {28'd0, be_out}, 32'd0);
            check($sformatf("sweep%0d_q", i), q, merge(32'h0, 32'hA5A5A5A5, vecs[i].be));
        end

        // Read held through SPLIT; it samples Q at its accepting edge, when
        // only the first chunk has landed.
        clear_reg();
        @(posedge clock);
        #1;
        bus.avs_writedata  = 32'hCAFEBABE;
        bus.avs_byteenable = 4'b1010;
        bus.avs_write      = 1'b1;
        @(posedge clock);
        #1;
        bus.avs_write = 1'b0;
        bus.avs_read  = 1'b1;
        @(negedge clock);
        check("rsplit_wait", {31'd0, bus.avs_waitrequest}, 32'd1);
        check("rsplit_c1", {28'd0, be_out}, 32'b0010);
        check("rsplit_rdv_held", {31'd0, bus.avs_readdatavalid}, 32'd0);
        @(negedge clock);
        check("rsplit_c2", {28'd0, be_out}, 32'b1000);
        check("rsplit_rdv_held2", {31'd0, bus.avs_readdatavalid}, 32'd0);
        @(posedge clock);
        #1;
        bus.avs_read = 1'b0;
        @(negedge clock);
        check("rsplit_rdv", {31'd0, bus.avs_readdatavalid}, 32'd1);
        check("rsplit_data", bus.avs_readdata, 32'h0000BA00);
        do_read("rsplit_full", 32'hCA00BA00);

        // Read right after a single-chunk write returns pre-write data
        @(posedge clock);
        #1;
        bus.avs_writedata  = 32'h01020304;
        bus.avs_byteenable = 4'hF;
        bus.avs_write      = 1'b1;
        @(posedge clock);
        #1;
        bus.avs_write = 1'b0;
        bus.avs_read  = 1'b1;
        @(posedge clock);
        #1;
        bus.avs_read = 1'b0;
        @(negedge clock);
        check("rafter_rdv", {31'd0, bus.avs_readdatavalid}, 32'd1);
        check("rafter_data", bus.avs_readdata, 32'hCA00BA00);
        check("rafter_q", q, 32'h01020304);

        // Back-to-back single-chunk writes, one per cycle
        @(posedge clock);
        #1;
        bus.avs_byteenable = 4'hF;
        bus.avs_writedata  = 32'h10000000;
        bus.avs_write      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (i < 2) bus.avs_writedata = 32'h10000000 + 32'(i + 1);
            else bus.avs_write = 1'b0;
            @(negedge clock);
            check($sformatf("b2b%0d_wait", i), {31'd0, bus.avs_waitrequest}, 32'd0);
            check($sformatf("b2b%0d_be", i), {28'd0, be_out}, 32'hF);
            check($sformatf("b2b%0d_D", i), d_out, 32'h10000000 + 32'(i));
        end
        @(negedge clock);
        check("b2b_q", q, 32'h10000002);

`ifdef BE_SPLIT_STATS_EN
        // Three split writes and two single-chunk writes
        sc0 = split_count;
        write_accept(32'h0, 4'b0111); @(negedge clock); @(negedge clock);
        write_accept(32'h0, 4'b1111); @(negedge clock); @(negedge clock);
        write_accept(32'h0, 4'b1001); @(negedge clock); @(negedge clock);
        write_accept(32'h0, 4'b0001); @(negedge clock); @(negedge clock);
        write_accept(32'h0, 4'b1110); @(negedge clock); @(negedge clock);
        check("stats_delta", {16'd0, split_count - sc0}, 32'd3);
`endif

        // Reset during SPLIT of 1001 abandons the write
        clear_reg();
        @(posedge clock);
        #1;
        bus.avs_writedata  = 32'h12345678;
        bus.avs_byteenable = 4'b1001;
        bus.avs_write      = 1'b1;
        @(posedge clock);
        #1;
        bus.avs_write = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_wait", {31'd0, bus.avs_waitrequest}, 32'd0);
        check("rstmid_be", {28'd0, be_out}, 32'd0);
        check("rstmid_D", d_out, 32'd0);
        check("rstmid_readdata", bus.avs_readdata, 32'd0);
        check("rstmid_rdv", {31'd0, bus.avs_readdatavalid}, 32'd0);
        nz_seen = 0;
        @(negedge clock);
        if (be_out != 4'b0000) nz_seen++;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (be_out != 4'b0000) nz_seen++;
        end
        check("rstmid_no_chunk", 32'(nz_seen), 32'd0);
        check("rstmid_q", q, 32'h0);

        // Randomized writes and reads against a byte-level memory model
        clear_reg();
        mem_model = 32'h0;
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                data = $urandom;
                be   = 4'($urandom_range(0, 15));
                write_accept(data, be);
                @(negedge clock);
                c1 = be_out;
                w1 = bus.avs_waitrequest;
                @(negedge clock);
                c2 = be_out;
                exp_n = (be == 4'b0000) ? 0 : (supported(be) ? 1 : 2);
                got_n = int'(c1 != 4'b0000) + int'(c2 != 4'b0000);
                check("rnd_cover", {28'd0, c1 | c2}, {28'd0, be});
                check("rnd_disjoint", {28'd0, c1 & c2}, 32'd0);
                check("rnd_c1_ok", {31'd0, supported(c1) || c1 == 4'b0000}, 32'd1);
                check("rnd_c2_ok", {31'd0, supported(c2) || c2 == 4'b0000}, 32'd1);
                check("rnd_nchunks", 32'(got_n), 32'(exp_n));
                check("rnd_wait", {31'd0, w1}, {31'd0, exp_n == 2});
                mem_model = merge(mem_model, data, be);
            end else if (op < 9) begin
                do_read("rnd_read", mem_model);
            end else begin
                @(negedge clock);
            end
        end
        @(negedge clock);
        check("rnd_final_q", q, mem_model);

        $display("%0d/%0d checks passed", n_pass, n_checks + proto_viol);
        $finish;
    end

endmodule
